// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM states, default operand
// width and the iteration-counter width helper.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  function automatic int mul_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int MUL_CNT_W = mul_cnt_width(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_add.sv
// add_32: gate-level WIDTH-bit adder with carry-out, built from 4-bit
// carry-lookahead groups that ripple into each other. WIDTH must be a multiple of 4.
module add_32
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUPS = WIDTH / 4;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
    localparam int B = gi * 4;
    logic       ci;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] cc;

    // Each group's carry-in is the previous group's carry-out.
    if (gi == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_cla[gi-1].cc[4];
    end

    assign p = a[B+3:B] ^ b[B+3:B];
    assign g = a[B+3:B] & b[B+3:B];

    assign cc[0] = ci;
    assign cc[1] = g[0] | (p[0] & ci);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & ci);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & ci);

    assign sum[B+3:B] = p ^ cc[3:0];
  end

  assign cout = g_cla[GROUPS-1].cc[4];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Unsigned shift-and-add multiplier controller: one shared adder, WIDTH iterations,
// 2*WIDTH-bit product. Optional early termination via macro MUL_EARLY_TERM_EN.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = mul_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] p_next;
  logic               early_hit;
  logic [2*WIDTH-1:0] early_p;

  assign addend = lo[0] ? mcand : '0;

  add_32 #(.WIDTH(WIDTH)) u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // The adder carry lands in the MSB of hi as the whole register shifts right.
  assign p_next = {carry, sum, lo[WIDTH-1:1]};

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] pending_mask;
  logic [CW-1:0]    drain;

  // Low WIDTH-count bits of lo are the multiplier bits not yet consumed.
  assign pending_mask = {WIDTH{1'b1}} >> count;
  assign drain        = CW'(WIDTH) - count;
  assign early_hit    = ((lo & pending_mask) == '0);
  assign early_p      = {hi, lo} >> drain;
`else
  assign early_hit = 1'b0;
  assign early_p   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= op_a;
            hi    <= '0;
            lo    <= op_b;
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (early_hit) begin
            product <= early_p;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            hi    <= p_next[2*WIDTH-1:WIDTH];
            lo    <= p_next[WIDTH-1:0];
            count <= count + 1'b1;
            if (count == LAST) begin
              product <= p_next;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed corners plus random operands against an
// arithmetic reference (product = a*b, latency from the multiplier's MSB).
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int passCount;
  int checkCount;
  int failCount;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  mul_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int expLatency(input logic [31:0] b);
    int msb;
    int early;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    early = (msb < 0) ? 1 : ((msb + 2 > 32) ? 32 : msb + 2);
    return EARLY_TERM ? early : 32;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit keep);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input logic [63:0] expProd, input int expLat,
                          input bit holdStart);
    int lat;
    bit busyDropped;
    lat         = 0;
    busyDropped = 1'b0;
    checkOutput({tag, " busy after accept"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      start = holdStart;
      op_a  = $urandom;
      op_b  = $urandom;
      @(posedge clk);
      #1;
      if (done) lat = k;
      else if (!busy) busyDropped = 1'b1;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " busy held"}, 64'(busyDropped), 64'd0);
    checkOutput({tag, " busy with done"}, 64'(busy), 64'd1);
    checkOutput({tag, " product"}, product, expProd);
    op_a = $urandom;
    op_b = $urandom;
    @(posedge clk);
    #1;
    checkOutput({tag, " done one cycle"}, 64'(done), 64'd0);
    checkOutput({tag, " busy released"}, 64'(busy), 64'd0);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] expProd;
    expProd = {32'd0, a} * {32'd0, b};
    applyStimulus(a, b, 1'b0);
    waitDone(tag, expProd, expLatency(b), 1'b0);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    failCount  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp(32'd7, 32'd6, "basic");
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    checkOutput("max literal", product, 64'hFFFF_FFFE_0000_0001);

    // start held high through CALC and DONE with changing operands
    applyStimulus(32'd5, 32'd5, 1'b1);
    waitDone("ignored first", 64'd25, expLatency(32'd5), 1'b1);
    op_a = 32'd3;
    op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored second", 64'd9, expLatency(32'd3), 1'b0);

    runOp(32'h8000_0000, 32'd2, "back to back");
    checkOutput("back to back literal", product, 64'h1_0000_0000);
    runOp(32'd9, 32'd0, "zero b");
    runOp(32'd9, 32'd1, "b one");
    runOp($urandom, 32'h8000_0000, "b msb");
    runOp(32'd0, 32'h1234_5678, "zero a");

    // abort mid-calculation
    applyStimulus(32'd7, 32'h8000_0006, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort product", product, 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runOp(32'd3, 32'd4, "after abort");

    for (int n = 0; n < 16; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      runOp(ra, rb, "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
